time_set: RTL and testbench

TIME_SET -- requirements
Module: time_set

---
 rtl/time_set.sv | 155 +++++++++++++++
 tb/tb_time_set.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/time_set.sv
// Time/alarm setting controller.
// Walks the user through hours, minutes and (for the clock only) seconds using
// three debounced push-buttons. When the edit is committed it emits a one-cycle
// load strobe to either the running clock or the alarm register. An inactivity
// timer abandons an edit without loading anything.
module time_set #(
  parameter int TIMEOUT = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_ok,
  input  logic       tgt,
  input  logic [3:0] cur_hr_t,
  input  logic [3:0] cur_hr_o,
  input  logic [3:0] cur_min_t,
  input  logic [3:0] cur_min_o,
  input  logic [3:0] cur_sec_t,
  input  logic [3:0] cur_sec_o,
  output logic [3:0] hr_t,
  output logic [3:0] hr_o,
  output logic [3:0] min_t,
  output logic [3:0] min_o,
  output logic [3:0] sec_t,
  output logic [3:0] sec_o,
  output logic       time_ow,
  output logic       alarm_set,
  output logic       editing,
  output logic [1:0] field
);

  localparam int            CW   = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, EDIT_HR, EDIT_MIN, EDIT_SEC, COMMIT} state_t;

  state_t        state, state_nxt;
  logic          primed, mode_q, inc_q, ok_q;
  logic          mode_e, inc_e, ok_e, in_edit;
  logic          tgt_q;
  logic [CW-1:0] cnt;
  logic [7:0]    hr, min, sec;

  // Hours increment in BCD: 23 wraps to 00, units 9 carry into tens.
  function automatic logic [7:0] inc_hr(input logic [7:0] v);
    if (v == 8'h23)          return 8'h00;
    else if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                     return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // Minutes/seconds increment in BCD: 59 wraps to 00 with no outward carry.
  function automatic logic [7:0] inc_ms(input logic [7:0] v);
    if (v[3:0] != 4'd9)      return {v[7:4], v[3:0] + 4'd1};
    else if (v[7:4] == 4'd5) return 8'h00;
    else                     return {v[7:4] + 4'd1, 4'd0};
  endfunction

  // primed stays low for the first cycle after reset so a button held through
  // reset release is absorbed into the previous-level registers, not seen as an edge.
  assign mode_e  = primed & btn_mode & ~mode_q;
  assign inc_e   = primed & btn_inc  & ~inc_q;
  assign ok_e    = primed & btn_ok   & ~ok_q;
  assign in_edit = (state == EDIT_HR) || (state == EDIT_MIN) || (state == EDIT_SEC);

  // Previous-level registers for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      primed <= 1'b0;
      mode_q <= 1'b0;
      inc_q  <= 1'b0;
      ok_q   <= 1'b0;
    end else begin
      primed <= 1'b1;
      mode_q <= btn_mode;
      inc_q  <= btn_inc;
      ok_q   <= btn_ok;
    end
  end

  // Next-state selection with ok > mode > inc priority and inactivity timeout.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_nxt unassigned
    // (which would infer a latch).
    state_nxt = state;
    unique case (state)
      IDLE:     if (mode_e) state_nxt = EDIT_HR;
      EDIT_HR, EDIT_MIN, EDIT_SEC: begin
        if (ok_e) begin
          state_nxt = COMMIT;
        end else if (mode_e) begin
          if (state == EDIT_HR)                 state_nxt = EDIT_MIN;
          else if (state == EDIT_MIN && !tgt_q) state_nxt = EDIT_SEC;
          else                                  state_nxt = COMMIT;
        end else if (!inc_e && cnt == LAST) begin
          state_nxt = IDLE;
        end
      end
      COMMIT:   state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // FSM state, registered status/strobe outputs, inactivity counter and edit digits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      editing   <= 1'b0;
      field     <= 2'd0;
      time_ow   <= 1'b0;
      alarm_set <= 1'b0;
      tgt_q     <= 1'b0;
      cnt       <= '0;
      hr        <= 8'h00;
      min       <= 8'h00;
      sec       <= 8'h00;
    end else begin
      state     <= state_nxt;
      editing   <= (state_nxt == EDIT_HR) || (state_nxt == EDIT_MIN) ||
                   (state_nxt == EDIT_SEC);
      unique case (state_nxt)
        EDIT_HR:  field <= 2'd1;
        EDIT_MIN: field <= 2'd2;
        EDIT_SEC: field <= 2'd3;
        default:  field <= 2'd0;
      endcase
      time_ow   <= (state_nxt == COMMIT) && !tgt_q;
      alarm_set <= (state_nxt == COMMIT) &&  tgt_q;

      if (in_edit && !(mode_e || inc_e || ok_e)) cnt <= cnt + 1'b1;
      else                                       cnt <= '0;

      if (state == IDLE && mode_e) begin
        tgt_q <= tgt;
        hr    <= {cur_hr_t,  cur_hr_o};
        min   <= {cur_min_t, cur_min_o};
        sec   <= {cur_sec_t, cur_sec_o};
      end else if (in_edit && inc_e && !mode_e && !ok_e) begin
        unique case (state)
          EDIT_HR:  hr  <= inc_hr(hr);
          EDIT_MIN: min <= inc_ms(min);
          EDIT_SEC: sec <= inc_ms(sec);
          default:  ;
        endcase
      end
    end
  end

  assign {hr_t,  hr_o}  = hr;
  assign {min_t, min_o} = min;
  assign {sec_t, sec_o} = sec;

endmodule

// File: tb/tb_time_set.sv
// Self-checking bench for time_set: scripted button sequences, expected output
// snapshots queued as each cycle is driven and compared one cycle later.
module tb_time_set;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_mode = 1'b0, btn_inc = 1'b0, btn_ok = 1'b0, tgt = 1'b0;
  logic [3:0] cur_hr_t = '0, cur_hr_o = '0, cur_min_t = '0;
  logic [3:0] cur_min_o = '0, cur_sec_t = '0, cur_sec_o = '0;
  logic [3:0] hr_t, hr_o, min_t, min_o, sec_t, sec_o;
  logic       time_ow, alarm_set, editing;
  logic [1:0] field;

  typedef struct packed {
    logic        ed;
    logic [1:0]  fld;
    logic [23:0] dig;
    logic        ow;
    logic        al;
  } snap_t;

  typedef struct {
    logic        m, i, o, t;
    logic [23:0] cur;
    snap_t       e;
  } row_t;

  snap_t exp_q[$];
  int    vectors = 0;
  int    miscompares = 0;

  time_set #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_ok(btn_ok), .tgt(tgt),
    .cur_hr_t(cur_hr_t), .cur_hr_o(cur_hr_o),
    .cur_min_t(cur_min_t), .cur_min_o(cur_min_o),
    .cur_sec_t(cur_sec_t), .cur_sec_o(cur_sec_o),
    .hr_t(hr_t), .hr_o(hr_o), .min_t(min_t), .min_o(min_o),
    .sec_t(sec_t), .sec_o(sec_o),
    .time_ow(time_ow), .alarm_set(alarm_set), .editing(editing), .field(field)
  );

  always #5 clk = ~clk;

  function automatic snap_t mk(input logic ed, input logic [1:0] fld,
                               input logic [23:0] dig, input logic ow, input logic al);
    snap_t s;
    s.ed = ed; s.fld = fld; s.dig = dig; s.ow = ow; s.al = al;
    return s;
  endfunction

  function automatic row_t rw(input logic m, input logic i, input logic o, input logic t,
                              input logic [23:0] cur, input snap_t e);
    row_t r;
    r.m = m; r.i = i; r.o = o; r.t = t; r.cur = cur; r.e = e;
    return r;
  endfunction

  function automatic snap_t observe();
    return mk(editing, field, {hr_t, hr_o, min_t, min_o, sec_t, sec_o}, time_ow, alarm_set);
  endfunction

  // Drive one cycle of levels, queue the snapshot due after the edge, sample #1 later.
  task automatic drive(input row_t r);
    @(negedge clk);
    btn_mode = r.m; btn_inc = r.i; btn_ok = r.o; tgt = r.t;
    {cur_hr_t, cur_hr_o, cur_min_t, cur_min_o, cur_sec_t, cur_sec_o} = r.cur;
    exp_q.push_back(r.e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    row_t  rows[$];
    snap_t got, want;
    snap_t z = mk(1'b0, 2'd0, 24'h0, 1'b0, 1'b0);
    rst_n = 1'b0;
    btn_mode = 1'b1;
    #3;
    got = observe();
    vectors++;
    if (got !== z) begin
      miscompares++;
      $display("FAIL reset_state: dut=%h model=%h", got, z);
    end
    @(negedge clk);
    rst_n = 1'b1;
    rows.push_back(rw(1, 0, 0, 0, 24'h233100, z));
    rows.push_back(rw(1, 0, 0, 0, 24'h233100, z));
    rows.push_back(rw(0, 0, 0, 0, 24'h233100, z));
    rows.push_back(rw(0, 1, 0, 0, 24'h233100, z));
    rows.push_back(rw(0, 0, 0, 0, 24'h233100, z));
    rows.push_back(rw(0, 0, 1, 0, 24'h233100, z));
    rows.push_back(rw(0, 0, 0, 0, 24'h233100, z));
    foreach (rows[k]) begin
      drive(rows[k]);
      want = exp_q.pop_front();
      got  = observe();
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL reset_idle[%0d]: dut=%h model=%h", k, got, want);
      end
    end
  endtask

  task automatic test_enter();
    row_t  rows[$];
    snap_t got, want;
    logic [23:0] c = 24'h233100;
    rows.push_back(rw(1, 0, 0, 0, c, mk(1, 1, 24'h233100, 0, 0)));
    rows.push_back(rw(0, 0, 0, 0, c, mk(1, 1, 24'h233100, 0, 0)));
    rows.push_back(rw(0, 1, 0, 0, c, mk(1, 1, 24'h003100, 0, 0)));
    rows.push_back(rw(0, 1, 0, 0, c, mk(1, 1, 24'h003100, 0, 0)));
    rows.push_back(rw(0, 0, 0, 0, c, mk(1, 1, 24'h003100, 0, 0)));
    rows.push_back(rw(0, 0, 1, 0, c, mk(0, 0, 24'h003100, 1, 0)));
    rows.push_back(rw(0, 0, 0, 0, c, mk(0, 0, 24'h003100, 0, 0)));
    foreach (rows[k]) begin
      drive(rows[k]);
      want = exp_q.pop_front();
      got  = observe();
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL enter[%0d]: dut=%h model=%h", k, got, want);
      end
    end
  endtask

  task automatic test_wrap();
    row_t  rows[$];
    snap_t got, want;
    logic [23:0] c = 24'h095859;
    rows.push_back(rw(1, 0, 0, 0, c, mk(1, 1, 24'h095859, 0, 0)));
    rows.push_back(rw(0, 0, 0, 0, c, mk(1, 1, 24'h095859, 0, 0)));
    rows.push_back(rw(0, 1, 0, 0, c, mk(1, 1, 24'h105859, 0, 0)));
    rows.push_back(rw(0, 0, 0, 0, c, mk(1, 1, 24'h105859, 0, 0)));
    rows.push_back(rw(1, 0, 0, 0, c, mk(1, 2, 24'h105859, 0, 0)));
    rows.push_back(rw(0, 0, 0, 0, c, mk(1, 2, 24'h105859, 0, 0)));
    rows.push_back(rw(0, 1, 0, 0, c, mk(1, 2, 24'h105959, 0, 0)));
    rows.push_back(rw(0, 0, 0, 0, c, mk(1, 2, 24'h105959, 0, 0)));
    rows.push_back(rw(0, 1, 0, 0, c, mk(1, 2, 24'h100059, 0, 0)));
    rows.push_back(rw(0, 0, 0, 0, c, mk(1, 2, 24'h100059, 0, 0)));
    rows.push_back(rw(1, 0, 0, 0, c, mk(1, 3, 24'h100059, 0, 0)));
    rows.push_back(rw(0, 0, 0, 0, c, mk(1, 3, 24'h100059, 0, 0)));
    rows.push_back(rw(0, 1, 0, 0, c, mk(1, 3, 24'h100000, 0, 0)));
    rows.push_back(rw(0, 0, 0, 0, c, mk(1, 3, 24'h100000, 0, 0)));
    rows.push_back(rw(0, 0, 1, 0, c, mk(0, 0, 24'h100000, 1, 0)));
    rows.push_back(rw(0, 0, 0, 0, c, mk(0, 0, 24'h100000, 0, 0)));
    foreach (rows[k]) begin
      drive(rows[k]);
      want = exp_q.pop_front();
      got  = observe();
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL wrap[%0d]: dut=%h model=%h", k, got, want);
      end
    end
  endtask

  task automatic test_commit_time();
    row_t  rows[$];
    snap_t got, want;
    logic [23:0] c = 24'h233300;
    rows.push_back(rw(1, 0, 0, 0, c, mk(1, 1, 24'h233300, 0, 0)));
    rows.push_back(rw(0, 0, 0, 1, c, mk(1, 1, 24'h233300, 0, 0)));
    rows.push_back(rw(0, 1, 0, 1, c, mk(1, 1, 24'h003300, 0, 0)));
    rows.push_back(rw(0, 0, 0, 1, c, mk(1, 1, 24'h003300, 0, 0)));
    rows.push_back(rw(1, 0, 0, 1, c, mk(1, 2, 24'h003300, 0, 0)));
    rows.push_back(rw(0, 0, 0, 1, c, mk(1, 2, 24'h003300, 0, 0)));
    rows.push_back(rw(1, 0, 0, 1, c, mk(1, 3, 24'h003300, 0, 0)));
    rows.push_back(rw(0, 0, 0, 1, c, mk(1, 3, 24'h003300, 0, 0)));
    rows.push_back(rw(1, 0, 0, 1, c, mk(0, 0, 24'h003300, 1, 0)));
    rows.push_back(rw(0, 0, 0, 1, 24'h120000, mk(0, 0, 24'h003300, 0, 0)));
    rows.push_back(rw(0, 0, 0, 0, 24'h120000, mk(0, 0, 24'h003300, 0, 0)));
    foreach (rows[k]) begin
      drive(rows[k]);
      want = exp_q.pop_front();
      got  = observe();
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL commit_time[%0d]: dut=%h model=%h", k, got, want);
      end
    end
  endtask

  task automatic test_alarm();
    row_t  rows[$];
    snap_t got, want;
    logic [23:0] c = 24'h074532;
    rows.push_back(rw(1, 0, 0, 1, c, mk(1, 1, 24'h074532, 0, 0)));
    rows.push_back(rw(0, 0, 0, 0, c, mk(1, 1, 24'h074532, 0, 0)));
    rows.push_back(rw(0, 1, 0, 0, c, mk(1, 1, 24'h084532, 0, 0)));
    rows.push_back(rw(0, 0, 0, 0, c, mk(1, 1, 24'h084532, 0, 0)));
    rows.push_back(rw(1, 0, 0, 0, c, mk(1, 2, 24'h084532, 0, 0)));
    rows.push_back(rw(0, 0, 0, 0, c, mk(1, 2, 24'h084532, 0, 0)));
    rows.push_back(rw(0, 1, 0, 0, c, mk(1, 2, 24'h084632, 0, 0)));
    rows.push_back(rw(0, 0, 0, 0, c, mk(1, 2, 24'h084632, 0, 0)));
    rows.push_back(rw(1, 0, 0, 0, c, mk(0, 0, 24'h084632, 0, 1)));
    rows.push_back(rw(0, 0, 0, 0, c, mk(0, 0, 24'h084632, 0, 0)));
    foreach (rows[k]) begin
      drive(rows[k]);
      want = exp_q.pop_front();
      got  = observe();
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL alarm[%0d]: dut=%h model=%h", k, got, want);
      end
    end
  endtask

  task automatic test_timeout_priority();
    row_t  rows[$];
    snap_t got, want;
    logic [23:0] c = 24'h123456;
    rows.push_back(rw(1, 0, 0, 0, c, mk(1, 1, c, 0, 0)));
    for (int k = 1; k < TO; k++) rows.push_back(rw(0, 0, 0, 0, c, mk(1, 1, c, 0, 0)));
    rows.push_back(rw(0, 0, 0, 0, c, mk(0, 0, c, 0, 0)));
    rows.push_back(rw(0, 0, 0, 0, c, mk(0, 0, c, 0, 0)));
    rows.push_back(rw(1, 0, 0, 0, c, mk(1, 1, c, 0, 0)));
    rows.push_back(rw(0, 0, 0, 0, c, mk(1, 1, c, 0, 0)));
    rows.push_back(rw(1, 1, 0, 0, c, mk(1, 2, c, 0, 0)));
    rows.push_back(rw(0, 0, 0, 0, c, mk(1, 2, c, 0, 0)));
    rows.push_back(rw(1, 1, 1, 0, c, mk(0, 0, c, 1, 0)));
    rows.push_back(rw(0, 0, 0, 0, c, mk(0, 0, c, 0, 0)));
    foreach (rows[k]) begin
      drive(rows[k]);
      want = exp_q.pop_front();
      got  = observe();
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL timeout_prio[%0d]: dut=%h model=%h", k, got, want);
      end
    end
  endtask

  task automatic test_reset_mid_edit();
    row_t  rows[$];
    snap_t got, want;
    logic [23:0] c = 24'h050607;
    snap_t z = mk(1'b0, 2'd0, 24'h0, 1'b0, 1'b0);
    rows.push_back(rw(1, 0, 0, 0, c, mk(1, 1, c, 0, 0)));
    rows.push_back(rw(0, 0, 0, 0, c, mk(1, 1, c, 0, 0)));
    rows.push_back(rw(1, 0, 0, 0, c, mk(1, 2, c, 0, 0)));
    rows.push_back(rw(0, 0, 0, 0, c, mk(1, 2, c, 0, 0)));
    foreach (rows[k]) begin
      drive(rows[k]);
      want = exp_q.pop_front();
      got  = observe();
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL mid_edit[%0d]: dut=%h model=%h", k, got, want);
      end
    end
    #2;
    btn_ok = 1'b1;
    rst_n  = 1'b0;
    #1;
    got = observe();
    vectors++;
    if (got !== z) begin
      miscompares++;
      $display("FAIL async_reset: dut=%h model=%h", got, z);
    end
    @(negedge clk);
    rst_n = 1'b1;
    rows.delete();
    rows.push_back(rw(0, 0, 1, 0, c, z));
    rows.push_back(rw(0, 0, 1, 0, c, z));
    rows.push_back(rw(0, 0, 0, 0, c, z));
    foreach (rows[k]) begin
      drive(rows[k]);
      want = exp_q.pop_front();
      got  = observe();
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL post_reset[%0d]: dut=%h model=%h", k, got, want);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_enter();
    test_wrap();
    test_commit_time();
    test_alarm();
    test_timeout_priority();
    test_reset_mid_edit();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
